// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for RV64M DIV/REM and W forms.
// One op in flight; result held until consumed over valid/ready.
module div_iter #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clock,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op_signed,
  input  logic            op_rem,
  input  logic            op_word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [XLEN-1:0]  rem, quo, dvsr;
  logic [CNT_W-1:0] cnt;
  logic             q_neg, r_neg;
  logic             rem_q, word_q;

  logic [XLEN-1:0] a_ext, b_ext;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN-1:0] min_val, sp, sp_w;
  logic            a_sgn, b_sgn;
  logic            is_zero, is_ovf;
  logic            special, accept;

  logic [XLEN:0]   rem_sh;
  logic            borrow;
  logic [XLEN-1:0] rem_nx, quo_nx;
  logic [XLEN-1:0] q_fin, r_fin, sel, fin;

  assign in_ready  = (state == IDLE) && !flush;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // Operand preparation at accept time
  always_comb begin
    a_ext = src1;
    b_ext = src2;
    if (op_word) begin
      a_ext = op_signed
        ? {{(XLEN-32){src1[31]}}, src1[31:0]}
        : {{(XLEN-32){1'b0}}, src1[31:0]};
      b_ext = op_signed
        ? {{(XLEN-32){src2[31]}}, src2[31:0]}
        : {{(XLEN-32){1'b0}}, src2[31:0]};
    end
    a_sgn   = op_signed & a_ext[XLEN-1];
    b_sgn   = op_signed & b_ext[XLEN-1];
    a_abs   = a_sgn ? -a_ext : a_ext;
    b_abs   = b_sgn ? -b_ext : b_ext;
    min_val = op_word
      ? {{(XLEN-31){1'b1}}, 31'b0}
      : {1'b1, {(XLEN-1){1'b0}}};
    is_zero = (b_ext == '0);
    is_ovf  = op_signed && (a_ext == min_val)
              && (b_ext == '1);
    special = is_zero || is_ovf;
    if (is_zero)
      sp = op_rem ? a_ext : '1;
    else
      sp = op_rem ? '0 : a_ext;
    sp_w = op_word
      ? {{(XLEN-32){sp[31]}}, sp[31:0]} : sp;
  end

  // One restoring step plus final sign fix-up
  always_comb begin
    rem_sh = {rem, quo[XLEN-1]};
    borrow = rem_sh < {1'b0, dvsr};
    rem_nx = borrow ? rem_sh[XLEN-1:0]
                    : rem_sh[XLEN-1:0] - dvsr;
    quo_nx = {quo[XLEN-2:0], ~borrow};
    q_fin  = q_neg ? -quo_nx : quo_nx;
    r_fin  = r_neg ? -rem_nx : rem_nx;
    sel    = rem_q ? r_fin : q_fin;
    fin    = word_q
      ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept)
              state_nx = special ? DONE : CALC;
      CALC: if (cnt == CNT_W'(1))
              state_nx = DONE;
      DONE: if (out_ready)
              state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush)
      state_nx = IDLE;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      cnt    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      rem_q  <= 1'b0;
      word_q <= 1'b0;
      result <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        rem    <= '0;
        quo    <= op_word ? (a_abs << 32) : a_abs;
        dvsr   <= b_abs;
        q_neg  <= a_sgn ^ b_sgn;
        r_neg  <= a_sgn;
        rem_q  <= op_rem;
        word_q <= op_word;
        if (special) begin
          cnt    <= '0;
          result <= sp_w;
        end else begin
          cnt <= op_word ? CNT_W'(32)
                         : CNT_W'(XLEN);
        end
      end else if (state == CALC && !flush) begin
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1))
          result <= fin;
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed scoreboard bench for div_iter.
// Checks results, latency, backpressure, flush and async reset.
module tb_div_iter;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op_signed = 1'b0;
  logic        op_rem = 1'b0;
  logic        op_word = 1'b0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;

  int checks = 0;
  int failures = 0;
  logic [63:0] sb[$];

  always #5 clock = ~clock;

  div_iter dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_signed (op_signed),
    .op_rem    (op_rem),
    .op_word   (op_word),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Drive one request, wait for out_valid, check latency and result
  task automatic issue(input bit s, input bit r,
                       input bit w,
                       input logic [63:0] a,
                       input logic [63:0] b,
                       input logic [63:0] e,
                       input int el,
                       input string tag);
    int lat;
    logic [63:0] exp;
    @(negedge clock);
    op_signed = s;
    op_rem    = r;
    op_word   = w;
    src1      = a;
    src2      = b;
    in_valid  = 1'b1;
    sb.push_back(e);
    #1;
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(el));
    if (sb.size() == 0) begin
      chk({tag, "_sb"}, 64'd0, 64'd1);
    end else begin
      exp = sb.pop_front();
      chk(tag, result, exp);
    end
  endtask

  task automatic drain(input string tag);
    @(negedge clock);
    out_ready = 1'b1;
    #1;
    chk({tag, "_busy"}, 64'(in_ready), 64'd0);
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    chk({tag, "_ov0"}, 64'(out_valid), 64'd0);
    chk({tag, "_ir1"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] held;
    int seen;
    #12;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    rst_n = 1'b1;

    issue(0, 0, 0, 64'd100, 64'd7, 64'd14, 65, "divu");
    drain("divu");
    issue(0, 1, 0, 64'd100, 64'd7, 64'd2, 65, "remu");
    drain("remu");
    issue(1, 0, 0, -64'sd7, 64'd2,
          64'hFFFF_FFFF_FFFF_FFFD, 65, "div_neg");
    drain("div_neg");
    issue(1, 1, 0, -64'sd7, 64'd2,
          64'hFFFF_FFFF_FFFF_FFFF, 65, "rem_neg");
    drain("rem_neg");
    issue(1, 1, 0, 64'd7, -64'sd2,
          64'd1, 65, "rem_pos");
    drain("rem_pos");
    issue(0, 0, 0, 64'd5, 64'd0,
          64'hFFFF_FFFF_FFFF_FFFF, 1, "divu_z");
    drain("divu_z");
    issue(0, 1, 0, 64'd5, 64'd0, 64'd5, 1, "remu_z");
    drain("remu_z");
    issue(1, 0, 0, 64'h8000_0000_0000_0000,
          64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 1, "div_ovf");
    drain("div_ovf");
    issue(1, 1, 0, 64'h8000_0000_0000_0000,
          64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, "rem_ovf");
    drain("rem_ovf");
    issue(1, 0, 1, 64'h0000_0000_8000_0000,
          64'h0000_0000_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, 1, "divw_ovf");
    drain("divw_ovf");
    issue(1, 0, 1, 64'h1234_5678_8000_0000, 64'd2,
          64'hFFFF_FFFF_C000_0000, 33, "divw");
    drain("divw");
    issue(0, 0, 1, 64'h0000_0000_FFFF_FFFF, 64'd1,
          64'hFFFF_FFFF_FFFF_FFFF, 33, "divuw");
    drain("divuw");
    issue(0, 1, 1, 64'hABCD_0000_0000_0064, 64'd7,
          64'd2, 33, "remuw");
    drain("remuw");

    // Backpressure: hold result for 10 cycles
    issue(0, 0, 0, 64'd1000, 64'd9, 64'd111, 65, "bp");
    held = 64'd111;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      chk("bp_stable", result, held);
      chk("bp_ir0", 64'(in_ready), 64'd0);
    end
    drain("bp");

    // Flush at CALC cycle 20, plus in_ready gating
    @(negedge clock);
    op_signed = 0; op_rem = 0; op_word = 0;
    src1 = 64'd500; src2 = 64'd3;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clock);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1;
    chk("fl_ov0", 64'(out_valid), 64'd0);
    chk("fl_ir_gated", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    #1;
    chk("fl_idle", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clock);
      #1;
      if (out_valid) seen++;
    end
    chk("fl_no_out", 64'(seen), 64'd0);
    chk("fl_ir_hold", 64'(in_ready), 64'd1);

    // Async reset mid-CALC
    @(negedge clock);
    src1 = 64'd77; src2 = 64'd5;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clock);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_ready", 64'(in_ready), 64'd1);
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_result", result, 64'd0);
    @(negedge clock);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clock);
      #1;
      if (out_valid) seen++;
    end
    chk("ar_no_out", 64'(seen), 64'd0);

    issue(1, 0, 0, -64'sd100, 64'd10,
          -64'sd10, 65, "post_rst");
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
